// File: rtl/pulse_pkg.sv
// Shared encodings for the trigger pulse generator: sequence modes and FSM states.
package pulse_pkg;

   typedef enum logic [1:0] {
      MODE_SINGLE = 2'd0,
      MODE_BURST  = 2'd1,
      MODE_CONT   = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DELAY = 2'd1,
      ST_HIGH  = 2'd2,
      ST_LOW   = 2'd3
   } state_t;

endpackage

// File: rtl/rise_detect.sv
// 1-bit rising-edge detector; the history register resets to 1 so a level held
// high through reset does not look like a fresh edge.
module rise_detect (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic rise
);

   logic q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) q <= 1'b1;
      else          q <= d;
   end

   assign rise = d & ~q;

endmodule

// File: rtl/trigger_pulse_gen.sv
// Trigger-started pulse sequencer: optional delay, then SINGLE / BURST / CONTINUOUS
// pulse trains of latched high/low lengths, with registered signal/busy/done.
module trigger_pulse_gen
   import pulse_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         on,
   input  logic [1:0]   mode,
   input  logic [W-1:0] delay,
   input  logic [W-1:0] high_len,
   input  logic [W-1:0] low_len,
   input  logic [W-1:0] count,
   output logic         signal,
   output logic         busy,
   output logic         done
);

   localparam logic [W-1:0] ONE = W'(1);

   logic         trig;
   state_t       state_q, state_d;
   mode_t        mode_q, mode_d;
   logic [W-1:0] cnt_q, cnt_d, hm1_q, hm1_d, lm1_q, lm1_d, rem_q, rem_d;
   logic [W-1:0] hm1_in, lm1_in;
   logic         stop_q, stop_d;
   logic         signal_d, busy_d, done_d;
   logic         stop_now, last_pulse, end_seq, start;

   rise_detect u_rise (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (on),
      .rise    (trig)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         mode_q  <= MODE_SINGLE;
         cnt_q   <= '0;
         hm1_q   <= '0;
         lm1_q   <= '0;
         rem_q   <= '0;
         stop_q  <= 1'b0;
         signal  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         hm1_q   <= hm1_d;
         lm1_q   <= lm1_d;
         rem_q   <= rem_d;
         stop_q  <= stop_d;
         signal  <= signal_d;
         busy    <= busy_d;
         done    <= done_d;
      end
   end

   always_comb begin
      // Phase lengths are stored minus one so zero-length fields clamp to one cycle.
      hm1_in   = (high_len == '0) ? '0 : high_len - ONE;
      lm1_in   = (low_len  == '0) ? '0 : low_len  - ONE;
      state_d  = state_q;
      mode_d   = mode_q;
      cnt_d    = cnt_q;
      hm1_d    = hm1_q;
      lm1_d    = lm1_q;
      rem_d    = rem_q;
      stop_now = stop_q | ~on;
      stop_d   = stop_now;
      signal_d = signal;
      busy_d   = busy;
      done_d   = 1'b0;
      end_seq  = 1'b0;
      start    = 1'b0;

      case (mode_q)
         MODE_BURST: last_pulse = (rem_q == ONE);
         MODE_CONT:  last_pulse = stop_now;
         default:    last_pulse = 1'b1;
      endcase

      case (state_q)
         ST_IDLE: begin
            stop_d = 1'b0;
            start  = trig;
         end
         ST_DELAY, ST_LOW: begin
            if (mode_q == MODE_CONT && stop_now) begin
               end_seq = 1'b1;
            end else if (cnt_q == '0) begin
               state_d  = ST_HIGH;
               cnt_d    = hm1_q;
               signal_d = 1'b1;
            end else begin
               cnt_d = cnt_q - ONE;
            end
         end
         ST_HIGH: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - ONE;
            end else if (last_pulse) begin
               end_seq = 1'b1;
            end else begin
               state_d  = ST_LOW;
               cnt_d    = lm1_q;
               signal_d = 1'b0;
               if (mode_q == MODE_BURST) rem_d = rem_q - ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A trigger on the completing edge restarts at once, so done and busy overlap here only.
      if (end_seq) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         signal_d = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b1;
         start    = trig;
      end

      if (start) begin
         mode_d = mode_t'(mode);
         hm1_d  = hm1_in;
         lm1_d  = lm1_in;
         rem_d  = (count == '0) ? ONE : count;
         stop_d = 1'b0;
         busy_d = 1'b1;
         if (delay != '0) begin
            state_d  = ST_DELAY;
            cnt_d    = delay - ONE;
            signal_d = 1'b0;
         end else begin
            state_d  = ST_HIGH;
            cnt_d    = hm1_in;
            signal_d = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen: per-cycle expected {signal,busy,done} are
// queued from closed-form pulse timing and popped one per clock edge.
module tb_trigger_pulse_gen;
   import pulse_pkg::*;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       on;
   logic [1:0] mode;
   logic [7:0] delay, high_len, low_len, count;
   logic       signal, busy, done;
   logic       signal4, busy4, done4;
   logic       sel4 = 1'b0;

   logic [2:0] q[$];
   int         vectors = 0;
   int         miscompares = 0;

   always #5 clock = ~clock;

   trigger_pulse_gen #(.W(8)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .on       (on),
      .mode     (mode),
      .delay    (delay),
      .high_len (high_len),
      .low_len  (low_len),
      .count    (count),
      .signal   (signal),
      .busy     (busy),
      .done     (done)
   );

   trigger_pulse_gen #(.W(4)) dut4 (
      .clock    (clock),
      .reset_n  (reset_n),
      .on       (on),
      .mode     (mode),
      .delay    (delay[3:0]),
      .high_len (high_len[3:0]),
      .low_len  (low_len[3:0]),
      .count    (count[3:0]),
      .signal   (signal4),
      .busy     (busy4),
      .done     (done4)
   );

   task automatic check_out(input string tag);
      logic [2:0] e, a;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
         return;
      end
      e = q.pop_front();
      a = sel4 ? {signal4, busy4, done4} : {signal, busy, done};
      vectors++;
      assert (a === e) else begin
         miscompares++;
         $error("FAIL %s: {signal,busy,done} observed %b expected %b", tag, a, e);
      end
   endtask

   // Trigger lands on relative edge 0; expectations derive from D, H, L and pulse count.
   task automatic run(input string tag, input logic [1:0] m, input int d, input int hl,
                      input int ll, input int cnt, input int npulses, input int len,
                      input int off_at, input int glitch_at, input bit scramble);
      int h, l, e;
      h = (hl == 0) ? 1 : hl;
      l = (ll == 0) ? 1 : ll;
      e = d + (npulses - 1) * (h + l) + h;
      for (int i = 0; i < len; i++) begin
         logic s;
         s = 1'b0;
         for (int p = 0; p < npulses; p++)
            if (i >= d + p * (h + l) && i < d + p * (h + l) + h) s = 1'b1;
         q.push_back({s, (i < e), (i == e)});
      end
      mode = m; delay = d[7:0]; high_len = hl[7:0]; low_len = ll[7:0]; count = cnt[7:0];
      on = 1'b1;
      for (int i = 0; i < len; i++) begin
         @(posedge clock); #1;
         check_out($sformatf("%s[%0d]", tag, i));
         if (scramble && i == 0) begin
            mode = 2'($urandom); delay = 8'($urandom); high_len = 8'($urandom);
            low_len = 8'($urandom); count = 8'($urandom);
         end
         if (off_at >= 0 && i + 1 >= off_at) on = 1'b0;
         if (glitch_at >= 0 && i + 1 == glitch_at) on = 1'b0;
         if (glitch_at >= 0 && i + 1 == glitch_at + 1) on = 1'b1;
      end
      on = 1'b0;
      repeat (2) @(posedge clock);
      #1;
   endtask

   task automatic expect_cycle(input string tag, input logic [2:0] e);
      q.push_back(e);
      @(posedge clock); #1;
      check_out(tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0; on = 1'b0; mode = MODE_SINGLE;
      delay = '0; high_len = '0; low_len = '0; count = '0;
      #3;
      q.push_back(3'b000);
      check_out("reset_state");
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      run("burst_d3", MODE_BURST, 3, 2, 1, 3, 3, 14, -1, -1, 1'b1);
      run("single_d0_h0", MODE_SINGLE, 0, 0, 5, 4, 1, 4, -1, -1, 1'b1);
      run("cont_stop", MODE_CONT, 1, 2, 2, 0, 2, 10, 7, -1, 1'b0);
      run("burst_retrig", MODE_BURST, 2, 2, 2, 2, 2, 12, -1, 3, 1'b1);
      run("burst_cnt0_l0", MODE_BURST, 0, 1, 0, 0, 1, 4, -1, -1, 1'b0);
      run("burst_l0", MODE_BURST, 1, 1, 0, 4, 4, 11, -1, -1, 1'b0);
      run("rsvd_mode", MODE_RSVD, 2, 3, 1, 5, 1, 8, -1, -1, 1'b0);
      run("burst_off_early", MODE_BURST, 1, 1, 2, 3, 3, 12, 2, -1, 1'b0);
      run("max_fields_w8", MODE_SINGLE, 255, 255, 1, 1, 1, 513, -1, -1, 1'b0);
      sel4 = 1'b1;
      run("max_fields_w4", MODE_SINGLE, 15, 15, 1, 1, 1, 33, -1, -1, 1'b0);
      sel4 = 1'b0;

      // Reset during the HIGH phase of a burst, with on held high through release.
      mode = MODE_BURST; delay = 8'd1; high_len = 8'd3; low_len = 8'd1; count = 8'd3;
      on = 1'b1;
      expect_cycle("rst_seq_start", 3'b010);
      expect_cycle("rst_seq_high0", 3'b110);
      expect_cycle("rst_seq_high1", 3'b110);
      #2 reset_n = 1'b0;
      #1;
      q.push_back(3'b000);
      check_out("rst_async");
      expect_cycle("rst_held0", 3'b000);
      expect_cycle("rst_held1", 3'b000);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 10; i++) expect_cycle($sformatf("no_retrig[%0d]", i), 3'b000);
      on = 1'b0;
      @(posedge clock); #1;
      run("after_reset", MODE_SINGLE, 2, 2, 1, 1, 1, 6, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
